// File: rtl/dp_pkg.sv
// Shared encodings for the multicycle datapath and its control unit.
// Select and op-code enums plus the reset instruction constant.
package dp_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'd0,
      RES_DATA      = 2'd1,
      RES_ALURESULT = 2'd2,
      RES_IMMEXT    = 2'd3
   } result_src_e;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'd0,
      SRCA_OLDPC = 2'd1,
      SRCA_A     = 2'd2,
      SRCA_ZERO  = 2'd3
   } srca_e;

   typedef enum logic [1:0] {
      SRCB_B    = 2'd0,
      SRCB_IMM  = 2'd1,
      SRCB_FOUR = 2'd2,
      SRCB_ZERO = 2'd3
   } srcb_e;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

endpackage

// File: rtl/dp_alu.sv
// Combinational XLEN-wide ALU with zero and signed/unsigned less-than flags.
// Shift amount uses only the low log2(XLEN) bits of b.
module dp_alu
   import dp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] y,
   output logic            zero,
   output logic            lt,
   output logic            ltu
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;

   assign shamt = b[SHW-1:0];
   assign lt    = $signed(a) < $signed(b);
   assign ltu   = a < b;

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLT:  y = XLEN'(lt);
         ALU_SLTU: y = XLEN'(ltu);
         ALU_SLL:  y = a << shamt;
         ALU_SRL:  y = a >> shamt;
         ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
         default:  y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RISC-V datapath: architectural registers, register file, extender,
// ALU and source/result muxes, sequenced cycle by cycle by an external controller.
module multicycle_datapath
   import dp_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = NOP_INSTR_C
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCWrite,
   input  logic            AdrSrc,
   input  logic            IRWrite,
   input  logic            MemValid,
   input  logic [1:0]      ResultSrc,
   input  logic [1:0]      ALUSrcA,
   input  logic [1:0]      ALUSrcB,
   input  logic [3:0]      ALUControl,
   input  logic [2:0]      ImmSrc,
   input  logic            RegWrite,
   input  logic [XLEN-1:0] ReadData,
   output logic [XLEN-1:0] Adr,
   output logic [XLEN-1:0] WriteData,
   output logic [31:0]     Instr,
   output logic            Zero,
   output logic            LT,
   output logic            LTU
);

   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   logic [XLEN-1:0] pc, old_pc, data, a_reg, b_reg, alu_out;
   logic [31:0]     instr;
   logic [XLEN-1:0] rf [0:31];

   logic [4:0]        rs1, rs2, rd;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]   imm_ext, src_a, src_b, alu_result, result;

   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];
   assign rd  = instr[11:7];

   // MemValid qualifies ReadData for the current cycle only: the memory may take
   // any number of cycles, and the controller holds IRWrite until MemValid arrives.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc      <= RESET_PC;
         old_pc  <= '0;
         instr   <= NOP_INSTR;
         data    <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         alu_out <= '0;
      end else begin
         if (PCWrite)
            pc <= {result[XLEN-1:1], 1'b0};
         if (IRWrite && MemValid) begin
            instr  <= ReadData[31:0];
            old_pc <= pc;
         end
         if (MemValid)
            data <= ReadData;
         a_reg   <= (rs1 == 5'd0) ? '0 : rf[rs1];
         b_reg   <= (rs2 == 5'd0) ? '0 : rf[rs2];
         alu_out <= alu_result;
      end
   end

   // Reads above see the pre-write value when rd matches rs1/rs2: no bypass.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (RegWrite && (rd != 5'd0)) begin
         rf[rd] <= result;
      end
   end

   always_comb begin
      imm32 = '0;
      case (ImmSrc)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   // imm32 is signed, so widening to XLEN sign-extends.
   assign imm_ext = XLEN'(imm32);

   always_comb begin
      src_a = '0;
      case (ALUSrcA)
         SRCA_PC:    src_a = pc;
         SRCA_OLDPC: src_a = old_pc;
         SRCA_A:     src_a = a_reg;
         default:    src_a = '0;
      endcase
   end

   always_comb begin
      src_b = '0;
      case (ALUSrcB)
         SRCB_B:    src_b = b_reg;
         SRCB_IMM:  src_b = imm_ext;
         SRCB_FOUR: src_b = FOUR;
         default:   src_b = '0;
      endcase
   end

   dp_alu #(.XLEN(XLEN)) u_alu (
      .a    (src_a),
      .b    (src_b),
      .op   (ALUControl),
      .y    (alu_result),
      .zero (Zero),
      .lt   (LT),
      .ltu  (LTU)
   );

   always_comb begin
      result = '0;
      case (ResultSrc)
         RES_ALUOUT:    result = alu_out;
         RES_DATA:      result = data;
         RES_ALURESULT: result = alu_result;
         default:       result = imm_ext;
      endcase
   end

   assign Adr       = AdrSrc ? result : pc;
   assign WriteData = b_reg;
   assign Instr     = instr;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: XLEN=32 instance for the main flow,
// XLEN=64 instance for wide shifts and reset vector.
module tb_multicycle_datapath;
   import dp_pkg::*;

   localparam logic [63:0] RESET_PC64 = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_write, adr_src, ir_write, mem_valid, reg_write;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic [3:0]  alu_control;
   logic [2:0]  imm_src;
   logic [31:0] rdata;

   logic [31:0] adr32, wd32, instr32;
   logic        zero32, lt32, ltu32;
   logic [63:0] adr64, wd64;
   logic [31:0] instr64;
   logic        zero64, lt64, ltu64;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] y;
      logic        z;
      logic        lt;
      logic        ltu;
   } vec_t;

   vec_t        vecs [15];
   logic [34:0] exp_q [$];

   always #5 clk = ~clk;

   multicycle_datapath #(.XLEN(32)) dut32 (
      .clk(clk), .reset(reset), .PCWrite(pc_write), .AdrSrc(adr_src),
      .IRWrite(ir_write), .MemValid(mem_valid), .ResultSrc(result_src),
      .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUControl(alu_control),
      .ImmSrc(imm_src), .RegWrite(reg_write), .ReadData(rdata),
      .Adr(adr32), .WriteData(wd32), .Instr(instr32),
      .Zero(zero32), .LT(lt32), .LTU(ltu32)
   );

   multicycle_datapath #(.XLEN(64), .RESET_PC(RESET_PC64)) dut64 (
      .clk(clk), .reset(reset), .PCWrite(pc_write), .AdrSrc(adr_src),
      .IRWrite(ir_write), .MemValid(mem_valid), .ResultSrc(result_src),
      .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUControl(alu_control),
      .ImmSrc(imm_src), .RegWrite(reg_write), .ReadData({32'h0, rdata}),
      .Adr(adr64), .WriteData(wd64), .Instr(instr64),
      .Zero(zero64), .LT(lt64), .LTU(ltu64)
   );

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      mem_valid   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_B;
      alu_control = ALU_ADD;
      imm_src     = IMM_I;
      reg_write   = 1'b0;
      rdata       = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, 5'b0, 7'h33};
   endfunction

   task automatic load_instr(input logic [31:0] ins);
      idle();
      rdata     = ins;
      ir_write  = 1'b1;
      mem_valid = 1'b1;
      tick();
      idle();
   endtask

   task automatic write_imm(input logic [31:0] ins, input logic [2:0] isrc);
      load_instr(ins);
      imm_src    = isrc;
      result_src = RES_IMMEXT;
      reg_write  = 1'b1;
      tick();
      idle();
   endtask

   task automatic write_data(input logic [31:0] ins, input logic [31:0] val);
      load_instr(ins);
      rdata     = val;
      mem_valid = 1'b1;
      tick();
      idle();
      result_src = RES_DATA;
      reg_write  = 1'b1;
      tick();
      idle();
   endtask

   // Route a register or OldPC straight through the ALU onto Adr.
   task automatic show_src(input logic [1:0] srca);
      idle();
      alu_src_a   = srca;
      alu_src_b   = SRCB_ZERO;
      alu_control = ALU_ADD;
      result_src  = RES_ALURESULT;
      adr_src     = 1'b1;
      #1;
   endtask

   task automatic show_alu(input logic [3:0] op);
      idle();
      alu_src_a   = SRCA_A;
      alu_src_b   = SRCB_B;
      alu_control = op;
      result_src  = RES_ALURESULT;
      adr_src     = 1'b1;
      #1;
   endtask

   initial begin
      // x1=-1 x2=1 x3=7 x4=7 x5=0x80000000 x6=-8 x7=4
      vecs[0]  = '{ALU_SUB,  5'd1, 5'd2, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{ALU_SUB,  5'd3, 5'd4, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{ALU_ADD,  5'd1, 5'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{ALU_AND,  5'd6, 5'd3, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{ALU_OR,   5'd6, 5'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{ALU_XOR,  5'd1, 5'd3, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{ALU_SLT,  5'd6, 5'd3, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{ALU_SLTU, 5'd6, 5'd3, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{ALU_SLL,  5'd2, 5'd7, 32'h0000_0010, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{ALU_SRL,  5'd5, 5'd7, 32'h0800_0000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{ALU_SRA,  5'd5, 5'd7, 32'hF800_0000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{ALU_SRA,  5'd6, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{4'hF,     5'd1, 5'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{ALU_SLT,  5'd3, 5'd6, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{ALU_SLL,  5'd5, 5'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

      // Reset held two cycles with enables active.
      idle();
      reset      = 1'b0;
      pc_write   = 1'b1;
      ir_write   = 1'b1;
      mem_valid  = 1'b1;
      reg_write  = 1'b1;
      rdata      = 32'h1234_5677;
      result_src = RES_DATA;
      repeat (2) tick();
      idle();
      #1;
      check("reset_pc", {32'h0, adr32}, 64'h0);
      check("reset_instr", {32'h0, instr32}, 64'h13);
      check("reset_pc64", adr64, RESET_PC64);
      reset = 1'b1;

      // Fetch with three wait cycles, PC+4 on the valid cycle.
      ir_write = 1'b1;
      rdata    = 32'h0050_0093;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("fetch_wait%0d_instr", i), {32'h0, instr32}, 64'h13);
      end
      mem_valid   = 1'b1;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_FOUR;
      alu_control = ALU_ADD;
      result_src  = RES_ALURESULT;
      pc_write    = 1'b1;
      tick();
      idle();
      #1;
      check("fetch_instr", {32'h0, instr32}, 64'h0050_0093);
      check("fetch_pc", {32'h0, adr32}, 64'h4);
      show_src(SRCA_OLDPC);
      check("fetch_oldpc", {32'h0, adr32}, 64'h0);
      idle();
      result_src = RES_DATA;
      adr_src    = 1'b1;
      #1;
      check("fetch_data", {32'h0, adr32}, 64'h0050_0093);

      // addi x1,x0,5: execute into ALUOut, then write back.
      idle();
      alu_src_a = SRCA_A;
      alu_src_b = SRCB_IMM;
      imm_src   = IMM_I;
      tick();
      idle();
      result_src = RES_ALUOUT;
      adr_src    = 1'b1;
      #1;
      check("addi_aluout", {32'h0, adr32}, 64'h5);
      reg_write = 1'b1;
      tick();
      idle();

      // Fetch at PC=4 with simultaneous PCWrite.
      ir_write    = 1'b1;
      mem_valid   = 1'b1;
      rdata       = 32'h0000_0013;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_FOUR;
      result_src  = RES_ALURESULT;
      pc_write    = 1'b1;
      tick();
      idle();
      #1;
      check("fetch2_pc", {32'h0, adr32}, 64'h8);
      show_src(SRCA_OLDPC);
      check("fetch2_oldpc", {32'h0, adr32}, 64'h4);

      load_instr(rtype(5'd1, 5'd0));
      tick();
      show_src(SRCA_A);
      check("x1_read", {32'h0, adr32}, 64'h5);

      // JALR-style target clears bit 0; MemValid without IRWrite leaves Instr alone.
      idle();
      rdata     = 32'h0000_1003;
      mem_valid = 1'b1;
      tick();
      idle();
      result_src = RES_DATA;
      pc_write   = 1'b1;
      tick();
      idle();
      #1;
      check("jalr_pc", {32'h0, adr32}, 64'h1002);
      check("instr_hold", {32'h0, instr32}, {32'h0, rtype(5'd1, 5'd0)});

      write_data(32'h0000_0033, 32'h0000_DEAD);
      tick();
      show_src(SRCA_A);
      check("x0_read", {32'h0, adr32}, 64'h0);

      // rd == rs1 == x9: A captured at the write edge must hold the old value.
      write_data(32'h0004_84B3, 32'hDEAD_BEEF);
      show_src(SRCA_A);
      check("no_bypass", {32'h0, adr32}, 64'h0);
      tick();
      show_src(SRCA_A);
      check("x9_read", {32'h0, adr32}, 64'hDEAD_BEEF);

      // Register preload for the ALU table.
      write_imm(32'hFFF0_0093, IMM_I);
      write_imm(32'h0010_0113, IMM_I);
      write_imm(32'h0070_0193, IMM_I);
      write_imm(32'h0070_0213, IMM_I);
      write_imm(32'h8000_02B7, IMM_U);
      write_imm(32'hFF80_0313, IMM_I);
      write_imm(32'h0040_0393, IMM_I);

      foreach (vecs[i])
         exp_q.push_back({vecs[i].y, vecs[i].z, vecs[i].lt, vecs[i].ltu});
      foreach (vecs[i]) begin
         logic [34:0] exp_v;
         load_instr(rtype(vecs[i].rs1, vecs[i].rs2));
         tick();
         show_alu(vecs[i].op);
         exp_v = exp_q.pop_front();
         check($sformatf("alu_vec%0d", i), {29'h0, adr32, zero32, lt32, ltu32}, {29'h0, exp_v});
      end

      load_instr(rtype(5'd3, 5'd5));
      tick();
      #1;
      check("writedata_b", {32'h0, wd32}, 64'h8000_0000);

      // Reset in the middle of an instruction discards everything.
      load_instr(rtype(5'd9, 5'd0));
      tick();
      reset       = 1'b0;
      alu_src_a   = SRCA_A;
      alu_src_b   = SRCB_ZERO;
      ir_write    = 1'b1;
      mem_valid   = 1'b1;
      rdata       = 32'h1234_5678;
      pc_write    = 1'b1;
      reg_write   = 1'b1;
      result_src  = RES_ALURESULT;
      tick();
      idle();
      #1;
      check("midreset_pc", {32'h0, adr32}, 64'h0);
      check("midreset_instr", {32'h0, instr32}, 64'h13);
      check("midreset_pc64", adr64, RESET_PC64);
      result_src = RES_ALUOUT;
      adr_src    = 1'b1;
      #1;
      check("midreset_aluout", {32'h0, adr32}, 64'h0);
      result_src = RES_DATA;
      #1;
      check("midreset_data", {32'h0, adr32}, 64'h0);
      show_src(SRCA_OLDPC);
      check("midreset_oldpc", {32'h0, adr32}, 64'h0);
      idle();
      reset = 1'b1;
      load_instr(rtype(5'd9, 5'd0));
      tick();
      show_src(SRCA_A);
      check("midreset_rf", {32'h0, adr32}, 64'h0);

      // 64-bit shifts: x1=1, x2=63, x3=x1<<x2, x5=64.
      write_imm(32'h0010_0093, IMM_I);
      write_imm(32'h03F0_0113, IMM_I);
      load_instr(32'h0020_81B3);
      tick();
      show_alu(ALU_SLL);
      check("x64_sll63", adr64, 64'h8000_0000_0000_0000);
      reg_write = 1'b1;
      tick();
      idle();
      write_imm(32'h0400_0293, IMM_I);
      load_instr(32'h0021_8233);
      tick();
      show_alu(ALU_SRA);
      check("x64_sra63", adr64, 64'hFFFF_FFFF_FFFF_FFFF);
      check("x64_sra_flags", {61'h0, zero64, lt64, ltu64}, 64'h2);
      check("x64_writedata", wd64, 64'd63);
      check("x64_instr", {32'h0, instr64}, 64'h0021_8233);
      load_instr(32'h0051_8033);
      tick();
      show_alu(ALU_SLL);
      check("x64_sll64", adr64, 64'h8000_0000_0000_0000);

      idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
